// File: rtl/set_assoc_cache_wb.sv
// N-way set-associative write-back / write-allocate cache with round-robin
// replacement, victim write-back and multi-beat line fills over a ready-handshaked memory port.
module set_assoc_cache_wb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rd_en,
    input  logic                  cpu_wr_en,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_hit,
    output logic                  cpu_rd_valid,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);
    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    // Memory handshake: a beat is transferred on any cycle where mem_rd or
    // mem_wr is high together with mem_ready; address/data hold until then.
    state_t                  state;
    logic [NUM_SETS-1:0]     valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0]     dirty_q [NUM_WAYS];
    logic [TAG_W-1:0]        tag_q   [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0]   data_q  [NUM_WAYS][NUM_SETS][LINE_WORDS];
    logic [WAY_W-1:0]        rr_q    [NUM_SETS];

    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic [WORD_W-1:0]       req_word;
    logic [DATA_WIDTH-1:0]   req_data;
    logic                    req_write;
    logic [WAY_W-1:0]        vic_q;
    logic [WORD_W-1:0]       beat;
    logic [WORD_W-1:0]       beat_nxt;
    logic                    last_beat;

    logic [TAG_W-1:0]        a_tag;
    logic [IDX_W-1:0]        a_idx;
    logic [WORD_W-1:0]       a_word;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic [WAY_W-1:0]        vic_way;

    assign a_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign a_idx     = cpu_addr[OFF_W+WORD_W +: IDX_W];
    assign a_word    = cpu_addr[OFF_W +: WORD_W];
    assign beat_nxt  = beat + 1'b1;
    assign last_beat = (beat == WORD_W'(LINE_WORDS - 1));

    generate
        if (OFF_W > 0) begin : g_unused_off
            logic unused_off;
            assign unused_off = ^cpu_addr[OFF_W-1:0];
        end
    endgenerate

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                        input logic [IDX_W-1:0] i,
                                                        input logic [WORD_W-1:0] b);
        logic [ADDR_WIDTH-1:0] a;
        a = ADDR_WIDTH'({t, i, b});
        return a << OFF_W;
    endfunction

    // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = rr_q[a_idx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][a_idx]) vic_way = WAY_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
            cpu_rd_data  <= '0;
            cpu_hit      <= 1'b0;
            cpu_rd_valid <= 1'b0;
            cpu_stall    <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wr_data  <= '0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_word     <= '0;
            req_data     <= '0;
            req_write    <= 1'b0;
            vic_q        <= '0;
            beat         <= '0;
        end else begin
            cpu_hit      <= 1'b0;
            cpu_rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_rd_en || cpu_wr_en) begin
                        if (hit) begin
                            cpu_hit <= 1'b1;
                            if (cpu_wr_en) begin
                                data_q[hit_way][a_idx][a_word] <= cpu_wr_data;
                                dirty_q[hit_way][a_idx]        <= 1'b1;
                                cpu_rd_data                    <= cpu_wr_data;
                            end else begin
                                cpu_rd_data <= data_q[hit_way][a_idx][a_word];
                            end
                        end else begin
                            req_tag   <= a_tag;
                            req_idx   <= a_idx;
                            req_word  <= a_word;
                            req_data  <= cpu_wr_data;
                            req_write <= cpu_wr_en;
                            vic_q     <= vic_way;
                            beat      <= '0;
                            cpu_stall <= 1'b1;
                            // The victim is invalid from here on so an aborted fill never looks resident.
                            valid_q[vic_way][a_idx] <= 1'b0;
                            if (valid_q[vic_way][a_idx] && dirty_q[vic_way][a_idx]) begin
                                state       <= WB;
                                mem_wr      <= 1'b1;
                                mem_addr    <= beat_addr(tag_q[vic_way][a_idx], a_idx, '0);
                                mem_wr_data <= data_q[vic_way][a_idx][0];
                            end else begin
                                state    <= FILL;
                                mem_rd   <= 1'b1;
                                mem_addr <= beat_addr(a_tag, a_idx, '0);
                            end
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        if (last_beat) begin
                            state    <= FILL;
                            mem_wr   <= 1'b0;
                            mem_rd   <= 1'b1;
                            beat     <= '0;
                            mem_addr <= beat_addr(req_tag, req_idx, '0);
                        end else begin
                            beat        <= beat_nxt;
                            mem_addr    <= beat_addr(tag_q[vic_q][req_idx], req_idx, beat_nxt);
                            mem_wr_data <= data_q[vic_q][req_idx][beat_nxt];
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        data_q[vic_q][req_idx][beat] <= mem_rdata;
                        if (last_beat) begin
                            state                   <= RESP;
                            mem_rd                  <= 1'b0;
                            valid_q[vic_q][req_idx] <= 1'b1;
                            dirty_q[vic_q][req_idx] <= 1'b0;
                            tag_q[vic_q][req_idx]   <= req_tag;
                            rr_q[req_idx]           <= rr_q[req_idx] + 1'b1;
                            cpu_stall               <= 1'b0;
                            cpu_rd_valid            <= 1'b1;
                            if (req_write)
                                cpu_rd_data <= req_data;
                            else if (req_word == beat)
                                cpu_rd_data <= mem_rdata;
                            else
                                cpu_rd_data <= data_q[vic_q][req_idx][req_word];
                        end else begin
                            beat     <= beat_nxt;
                            mem_addr <= beat_addr(req_tag, req_idx, beat_nxt);
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (req_write) begin
                        data_q[vic_q][req_idx][req_word] <= req_data;
                        dirty_q[vic_q][req_idx]          <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_wb.sv
// Scoreboarded bench for set_assoc_cache_wb: memory beats and CPU responses
// are predicted when stimulus is driven and compared as the DUT produces them.
module tb_set_assoc_cache_wb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] PAT = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic          cpu_rd_en;
    logic          cpu_wr_en;
    logic [DW-1:0] cpu_wr_data;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_hit;
    logic          cpu_rd_valid;
    logic          cpu_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    set_assoc_cache_wb dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_hit(cpu_hit),
        .cpu_rd_valid(cpu_rd_valid), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wr_data(mem_wr_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign mem_rdata = mem_addr ^ PAT;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW:0]      exp_q[$];   // {is_hit, data}
    logic [AW+DW:0]   beat_q[$];  // {is_write, addr, write data (0 for reads)}
    int resp_cnt = 0;
    logic [AW-1:0] hold_addr = '0;
    int hold_left = 0;
    int held_cycles = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory wait-state generator: stalls a chosen beat for hold_left cycles.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_left > 0 && mem_rd && mem_addr == hold_addr) begin
                mem_ready = 1'b0;
                hold_left--;
                held_cycles++;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor: compares accepted beats and CPU responses against the queues.
    always @(negedge clk) begin
        logic [AW+DW:0] eb;
        logic [DW:0]    er;
        if (!rst) begin
            if (mem_rd || mem_wr) check("rd_wr_exclusive", 80'(mem_rd & mem_wr), 80'(0));
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (beat_q.size() == 0) begin
                    check("extra_beat", 80'({mem_wr, mem_rd, mem_addr}), 80'(0));
                end else begin
                    eb = beat_q.pop_front();
                    check("beat", 80'({mem_wr, mem_addr, (mem_wr ? mem_wr_data : 32'h0)}), 80'(eb));
                end
            end
            if (cpu_hit || cpu_rd_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_resp", 80'({cpu_hit, cpu_rd_valid, cpu_rd_data}), 80'(0));
                end else begin
                    er = exp_q.pop_front();
                    check(er[DW] ? "hit_resp" : "miss_resp",
                          80'({cpu_hit, cpu_rd_valid, cpu_rd_data}),
                          80'({er[DW], ~er[DW], er[DW-1:0]}));
                end
                if (cpu_rd_valid) check("stall_in_resp", 80'(cpu_stall), 80'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_line(input logic wr, input logic [AW-1:0] base, input logic [DW-1:0] d0);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = base + AW'(4 * i);
            d = wr ? ((i == 0) ? d0 : (a ^ PAT)) : '0;
            beat_q.push_back({wr, a, d});
        end
    endtask

    task automatic cpu_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic exp_hit, input logic [DW-1:0] exp_data, input logic poke);
        int start;
        start = resp_cnt;
        exp_q.push_back({exp_hit, exp_data});
        @(negedge clk);
        cpu_addr    = addr;
        cpu_wr_en   = wr;
        cpu_rd_en   = !wr;
        cpu_wr_data = data;
        @(negedge clk);
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        check(exp_hit ? "stall_after_hit" : "stall_after_miss", 80'(cpu_stall), 80'(!exp_hit));
        if (poke) begin
            // A resident line requested while stalled must be ignored.
            cpu_addr  = 32'h2000;
            cpu_rd_en = 1'b1;
            @(negedge clk);
            cpu_rd_en = 1'b0;
        end
        for (int i = 0; i < 100 && resp_cnt == start; i++) @(negedge clk);
        if (resp_cnt == start) check("resp_timeout", 80'(resp_cnt), 80'(start + 1));
        check("stall_idle", 80'(cpu_stall), 80'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, 80'({cpu_rd_data, cpu_hit, cpu_rd_valid, cpu_stall, mem_rd, mem_wr}), 80'(0));
        check(tag, 80'({mem_addr, mem_wr_data}), 80'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int t;
        rst = 1'b1;
        cpu_addr = '0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_wr_data = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst = 1'b0;

        // 1: read miss, clean fill into way0 of set 0
        push_line(1'b0, 32'h1000, '0);
        cpu_req(1'b0, 32'h1000, '0, 1'b0, 32'hA5A5B5A5, 1'b0);
        check("s1_beats_left", 80'(beat_q.size()), 80'(0));

        // 2: read hit in same line
        cpu_req(1'b0, 32'h1004, '0, 1'b1, 32'hA5A5B5A1, 1'b0);

        // 3: write miss into invalid way1, then read it back
        push_line(1'b0, 32'h2000, '0);
        cpu_req(1'b1, 32'h2000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
        cpu_req(1'b0, 32'h2000, '0, 1'b1, 32'hDEADBEEF, 1'b0);

        // 4: clean eviction of way0, then dirty eviction of way1
        push_line(1'b0, 32'h3000, '0);
        cpu_req(1'b0, 32'h3000, '0, 1'b0, 32'hA5A595A5, 1'b1);
        push_line(1'b1, 32'h2000, 32'hDEADBEEF);
        push_line(1'b0, 32'h4000, '0);
        cpu_req(1'b0, 32'h4000, '0, 1'b0, 32'hA5A5E5A5, 1'b0);
        check("s4_beats_left", 80'(beat_q.size()), 80'(0));

        // 5: wait states on fill beat 2
        hold_addr = 32'h1008; held_cycles = 0; hold_left = 3;
        push_line(1'b0, 32'h1000, '0);
        cpu_req(1'b0, 32'h1000, '0, 1'b0, 32'hA5A5B5A5, 1'b0);
        check("s5_held_cycles", 80'(held_cycles), 80'(3));
        check("s5_beats_left", 80'(beat_q.size()), 80'(0));

        // 6: reset during fill beat 1 aborts the miss
        hold_addr = 32'h5004; held_cycles = 0; hold_left = 1000;
        push_line(1'b0, 32'h5000, '0);
        @(negedge clk);
        cpu_addr = 32'h5000; cpu_rd_en = 1'b1;
        @(negedge clk);
        cpu_rd_en = 1'b0;
        t = 0;
        while (!(mem_rd && mem_addr == 32'h5004 && !mem_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("s6_reach_beat1", 80'({mem_rd, mem_addr}), 80'({1'b1, 32'h5004}));
        check("s6_beats_left", 80'(beat_q.size()), 80'(3));
        rst = 1'b1;
        beat_q.delete();
        exp_q.delete();
        @(negedge clk);
        check_outputs_zero("s6_reset_outputs");
        rst = 1'b0;
        hold_left = 0;
        @(negedge clk);
        check("s6_no_beats_after", 80'({mem_rd, mem_wr, cpu_stall}), 80'(0));
        push_line(1'b0, 32'h1000, '0);
        cpu_req(1'b0, 32'h1000, '0, 1'b0, 32'hA5A5B5A5, 1'b0);
        check("s6_refill_beats_left", 80'(beat_q.size()), 80'(0));

        // 7: hits on every word of the refilled line, then write/read-back hits
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + AW'(4 * i);
            cpu_req(1'b0, a, '0, 1'b1, a ^ PAT, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + AW'(4 * $urandom_range(0, 3));
            d = $urandom();
            cpu_req(1'b1, a, d, 1'b1, d, 1'b0);
            cpu_req(1'b0, a, '0, 1'b1, d, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("final_exp_q_empty", 80'(exp_q.size()), 80'(0));
        check("final_beat_q_empty", 80'(beat_q.size()), 80'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
